// File: rtl/tri_edge_sequencer.sv
// tri_edge_sequencer
//   Takes one triangle per handshake and walks its three edges (AB, BC, CA)
//   through the downstream Bresenham line engine. For each edge it loads the
//   endpoints, pulses the engine start, and waits for the engine finish.
//   If an edge runs too long, the triangle is abandoned and timeout_err pulses.
//   Optional build macro: TRI_EDGE_SORT_EN. When it is defined, each edge is
//   normalised so that x1<x2, or y1<=y2 when x1==x2.
//   dbg_state exposes the FSM state for checkers.
module tri_edge_sequencer #(
    parameter int COORD_W      = 32,
    parameter int START_CYCLES = 2,
    parameter int TIMEOUT      = 2048
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tri_valid,
    output logic               tri_ready,
    input  logic [9:0]         ax,
    input  logic [9:0]         bx,
    input  logic [9:0]         cx,
    input  logic [8:0]         ay,
    input  logic [8:0]         by,
    input  logic [8:0]         cy,
    output logic               line_start,
    output logic [COORD_W-1:0] line_x1,
    output logic [COORD_W-1:0] line_y1,
    output logic [COORD_W-1:0] line_x2,
    output logic [COORD_W-1:0] line_y2,
    input  logic               line_finish,
    output logic               busy,
    output logic [1:0]         edge_idx,
    output logic               done,
    output logic               timeout_err,
    output logic [2:0]         dbg_state
);
    // Handshake: a triangle transfers on a rising edge where tri_valid and
    // tri_ready are both high. tri_ready is high only in IDLE and never
    // depends on tri_valid. Once the offer is accepted, the inputs may change.

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_START = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    // A single counter serves both the START hold and the WAIT timeout
    localparam int CNT_MAX = (TIMEOUT > START_CYCLES) ? TIMEOUT : START_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(TIMEOUT - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         edge_q, edge_d;
    logic [9:0]         ax_q, bx_q, cx_q, ax_d, bx_d, cx_d;
    logic [8:0]         ay_q, by_q, cy_q, ay_d, by_d, cy_d;
    logic [COORD_W-1:0] x1_q, y1_q, x2_q, y2_q;
    logic [COORD_W-1:0] x1_d, y1_d, x2_d, y2_d;
    logic [9:0]         px, qx;
    logic [8:0]         py, qy;
`ifdef TRI_EDGE_SORT_EN
    logic [9:0]         sx;
    logic [8:0]         sy;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic: line_finish is only looked at in WAIT, so a stale finish is ignored
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (tri_valid) state_d = S_LOAD;
            S_LOAD:  state_d = S_START;
            S_START: if (cnt_q == START_LAST) state_d = S_WAIT;
            S_WAIT: begin
                if (line_finish)             state_d = (edge_q == 2'd2) ? S_DONE : S_LOAD;
                else if (cnt_q == WAIT_LAST) state_d = S_ERR;
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next values: cycle counter, edge index, vertex capture, endpoint select
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q)                        cnt_d = '0;
        else if (state_q == S_START || state_q == S_WAIT) cnt_d = cnt_q + CNT_W'(1);

        edge_d = edge_q;
        ax_d = ax_q; bx_d = bx_q; cx_d = cx_q;
        ay_d = ay_q; by_d = by_q; cy_d = cy_q;
        if (state_q == S_IDLE && tri_valid) begin
            edge_d = 2'd0;
            ax_d = ax; bx_d = bx; cx_d = cx;
            ay_d = ay; by_d = by; cy_d = cy;
        end else if (state_q == S_WAIT && line_finish && edge_q != 2'd2) begin
            edge_d = edge_q + 2'd1;
        end

        // Endpoints are computed for the upcoming edge so they are valid throughout LOAD
        case (edge_d)
            2'd0:    begin px = ax_d; py = ay_d; qx = bx_d; qy = by_d; end
            2'd1:    begin px = bx_d; py = by_d; qx = cx_d; qy = cy_d; end
            default: begin px = cx_d; py = cy_d; qx = ax_d; qy = ay_d; end
        endcase
`ifdef TRI_EDGE_SORT_EN
        sx = px;
        sy = py;
        if (px > qx || (px == qx && py > qy)) begin
            px = qx; py = qy;
            qx = sx; qy = sy;
        end
`endif

        x1_d = x1_q; y1_d = y1_q; x2_d = x2_q; y2_d = y2_q;
        if (state_d == S_LOAD) begin
            x1_d = COORD_W'(px); y1_d = COORD_W'(py);
            x2_d = COORD_W'(qx); y2_d = COORD_W'(qy);
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            edge_q <= 2'd0;
            ax_q <= '0; bx_q <= '0; cx_q <= '0;
            ay_q <= '0; by_q <= '0; cy_q <= '0;
            x1_q <= '0; y1_q <= '0; x2_q <= '0; y2_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            edge_q <= edge_d;
            ax_q <= ax_d; bx_q <= bx_d; cx_q <= cx_d;
            ay_q <= ay_d; by_q <= by_d; cy_q <= cy_d;
            x1_q <= x1_d; y1_q <= y1_d; x2_q <= x2_d; y2_q <= y2_d;
        end
    end

    // Outputs decoded from state: line_start stays high everywhere except WAIT, so the engine is parked
    always_comb begin
        tri_ready   = (state_q == S_IDLE);
        line_start  = (state_q != S_WAIT);
        busy        = (state_q != S_IDLE);
        done        = (state_q == S_DONE);
        timeout_err = (state_q == S_ERR);
        dbg_state   = state_q;
    end

    assign line_x1  = x1_q;
    assign line_y1  = y1_q;
    assign line_x2  = x2_q;
    assign line_y2  = y2_q;
    assign edge_idx = edge_q;

endmodule

// File: tb/tb_tri_edge_sequencer.sv
// Bench for tri_edge_sequencer with a behavioural line-engine stub.
module tb_tri_edge_sequencer;
    localparam int CW = 32;
    localparam int SC = 3;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          tri_valid = 1'b0;
    logic          tri_ready;
    logic [9:0]    ax = '0, bx = '0, cx = '0;
    logic [8:0]    ay = '0, by = '0, cy = '0;
    logic          line_start;
    logic [CW-1:0] line_x1, line_y1, line_x2, line_y2;
    logic          line_finish;
    logic          busy;
    logic [1:0]    edge_idx;
    logic          done, timeout_err;
    logic [2:0]    dbg_state;

    int checks = 0;
    int failures = 0;

    // Engine stub controls
    int fin_delay  = 0;
    bit never_fin  = 0;
    bit stale_hold = 0;
    int low_cnt    = 0;

    tri_edge_sequencer #(.COORD_W(CW), .START_CYCLES(SC), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .tri_valid(tri_valid), .tri_ready(tri_ready),
        .ax(ax), .bx(bx), .cx(cx), .ay(ay), .by(by), .cy(cy),
        .line_start(line_start), .line_x1(line_x1), .line_y1(line_y1),
        .line_x2(line_x2), .line_y2(line_y2), .line_finish(line_finish),
        .busy(busy), .edge_idx(edge_idx), .done(done), .timeout_err(timeout_err),
        .dbg_state(dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    // Engine stub: finish rises fin_delay cycles after start falls; stale_hold drives finish while start is high
    always @(negedge clk) begin
        if (line_start) begin
            low_cnt = 0;
            line_finish = stale_hold;
        end else begin
            line_finish = !never_fin && (low_cnt >= fin_delay);
            low_cnt++;
        end
    end

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [127:0] exp_q[$];
    logic [127:0] obs_q[$];
    int first_wait, done_c, err_c, done_cnt, err_cnt, stab_bad, err_edge;
    bit ready_after, busy_after, run_hung;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; tri_valid = 1'b0; stale_hold = 0; never_fin = 0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Reference: an edge joins vertex e to vertex (e+1)%3, optionally normalised
    function automatic logic [127:0] pack_edge(logic [9:0] px, logic [8:0] py, logic [9:0] qx, logic [8:0] qy);
`ifdef TRI_EDGE_SORT_EN
        logic [9:0] tx;
        logic [8:0] ty;
        if (px > qx || (px == qx && py > qy)) begin
            tx = px; ty = py; px = qx; py = qy; qx = tx; qy = ty;
        end
`endif
        return {32'(px), 32'(py), 32'(qx), 32'(qy)};
    endfunction

    task automatic build_exp(input logic [9:0] xa, input logic [8:0] ya, input logic [9:0] xb,
                             input logic [8:0] yb, input logic [9:0] xc, input logic [8:0] yc);
        logic [9:0] vx[3];
        logic [8:0] vy[3];
        vx[0] = xa; vx[1] = xb; vx[2] = xc;
        vy[0] = ya; vy[1] = yb; vy[2] = yc;
        exp_q.delete();
        for (int e = 0; e < 3; e++) exp_q.push_back(pack_edge(vx[e], vy[e], vx[(e+1)%3], vy[(e+1)%3]));
    endtask

    // Driver + monitor: offers one triangle, records each issued edge and the completion timing
    task automatic run_tri(input logic [9:0] xa, input logic [8:0] ya, input logic [9:0] xb,
                           input logic [8:0] yb, input logic [9:0] xc, input logic [8:0] yc,
                           input int dly, input bit never, input bit stale);
        bit prev_start;
        bit fin_seen;
        int c;
        obs_q.delete();
        first_wait = -1; done_c = -1; err_c = -1; done_cnt = 0; err_cnt = 0;
        stab_bad = 0; run_hung = 0; err_edge = -1;
        fin_delay = dly; never_fin = never; stale_hold = stale;
        ax = xa; ay = ya; bx = xb; by = yb; cx = xc; cy = yc;
        tri_valid = 1'b1;
        tick();
        tri_valid = 1'b0;
        prev_start = 1'b1; c = 1; fin_seen = 0;
        while (!fin_seen && c < 400) begin
            if (prev_start && !line_start) begin
                obs_q.push_back({line_x1, line_y1, line_x2, line_y2});
                if (first_wait < 0) first_wait = c;
            end else if (!line_start && obs_q.size() > 0) begin
                if (obs_q[$] !== {line_x1, line_y1, line_x2, line_y2}) stab_bad++;
            end
            if (done) begin done_cnt++; done_c = c; fin_seen = 1; end
            if (timeout_err) begin err_cnt++; err_c = c; err_edge = int'(edge_idx); fin_seen = 1; end
            prev_start = line_start;
            tick(); c++;
        end
        run_hung = !fin_seen;
        ready_after = tri_ready;
        busy_after = busy;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (done) done_cnt++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tri_valid = 1'b1; ax = 10'd5; bx = 10'd6; cx = 10'd7;
        tick(); tick();
        checks++; if (tri_ready !== 1'b1) begin failures++; $display("FAIL reset_tri_ready got=%b exp=1", tri_ready); end
        checks++; if (line_start !== 1'b1) begin failures++; $display("FAIL reset_line_start got=%b exp=1", line_start); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (edge_idx !== 2'd0) begin failures++; $display("FAIL reset_edge_idx got=%0d exp=0", edge_idx); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL reset_timeout_err got=%b exp=0", timeout_err); end
        checks++;
        if ({line_x1, line_y1, line_x2, line_y2} !== 128'd0) begin
            failures++; $display("FAIL reset_line_coords got=%h exp=0", {line_x1, line_y1, line_x2, line_y2});
        end
        tri_valid = 1'b0;
        rst_n = 1'b1;
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_release_busy got=%b exp=0", busy); end
    endtask

    task automatic test_edge_order();
        do_reset();
        exp_q.delete();
`ifdef TRI_EDGE_SORT_EN
        exp_q.push_back({32'd10, 32'd20, 32'd20, 32'd20});
        exp_q.push_back({32'd10, 32'd30, 32'd20, 32'd20});
        exp_q.push_back({32'd10, 32'd20, 32'd10, 32'd30});
`else
        exp_q.push_back({32'd10, 32'd20, 32'd20, 32'd20});
        exp_q.push_back({32'd20, 32'd20, 32'd10, 32'd30});
        exp_q.push_back({32'd10, 32'd30, 32'd10, 32'd20});
`endif
        run_tri(10'd10, 9'd20, 10'd20, 9'd20, 10'd10, 9'd30, 12, 0, 0);
        checks++; if (run_hung) begin failures++; $display("FAIL order_hang got=hung exp=done"); end
        checks++; if (obs_q.size() != 3) begin failures++; $display("FAIL order_edge_count got=%0d exp=3", obs_q.size()); end
        for (int i = 0; i < obs_q.size() && i < 3; i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL order_edge%0d got=%h exp=%h", i, obs_q[i], exp_q[i]); end
        end
        checks++; if (first_wait != 2 + SC) begin failures++; $display("FAIL order_first_wait got=%0d exp=%0d", first_wait, 2 + SC); end
        checks++; if (done_c != 1 + 3 * (SC + 12 + 2)) begin failures++; $display("FAIL order_done_cycle got=%0d exp=%0d", done_c, 1 + 3 * (SC + 14)); end
        checks++; if (done_cnt != 1) begin failures++; $display("FAIL order_done_pulses got=%0d exp=1", done_cnt); end
        checks++; if (busy_after !== 1'b0) begin failures++; $display("FAIL order_busy_after_done got=%b exp=0", busy_after); end
        checks++; if (ready_after !== 1'b1) begin failures++; $display("FAIL order_ready_after_done got=%b exp=1", ready_after); end
        checks++; if (stab_bad != 0) begin failures++; $display("FAIL order_line_stable got=%0d exp=0", stab_bad); end
    endtask

    task automatic test_random();
        logic [9:0] xa, xb, xc;
        logic [8:0] ya, yb, yc;
        int dly;
        do_reset();
        for (int t = 0; t < 8; t++) begin
            xa = 10'($urandom_range(0, 639)); ya = 9'($urandom_range(0, 479));
            if (t == 0) begin
                xb = xa; yb = ya; xc = xa; yc = ya;
            end else begin
                xb = 10'($urandom_range(0, 639)); yb = 9'($urandom_range(0, 479));
                xc = (t == 1) ? xa : 10'($urandom_range(0, 639));
                yc = 9'($urandom_range(0, 479));
            end
            dly = $urandom_range(0, 12);
            build_exp(xa, ya, xb, yb, xc, yc);
            run_tri(xa, ya, xb, yb, xc, yc, dly, 0, 0);
            checks++; if (obs_q.size() != 3) begin failures++; $display("FAIL rand%0d_edge_count got=%0d exp=3", t, obs_q.size()); end
            for (int i = 0; i < obs_q.size() && i < 3; i++) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL rand%0d_edge%0d got=%h exp=%h", t, i, obs_q[i], exp_q[i]); end
            end
            checks++;
            if (done_c != 1 + 3 * (SC + dly + 2)) begin
                failures++; $display("FAIL rand%0d_done_cycle got=%0d exp=%0d", t, done_c, 1 + 3 * (SC + dly + 2));
            end
            checks++; if (stab_bad != 0 || done_cnt != 1) begin failures++; $display("FAIL rand%0d_stable_done got=%0d/%0d exp=0/1", t, stab_bad, done_cnt); end
        end
    endtask

    task automatic test_stale_finish();
        do_reset();
        build_exp(10'd100, 9'd200, 10'd300, 9'd100, 10'd50, 9'd400);
        run_tri(10'd100, 9'd200, 10'd300, 9'd100, 10'd50, 9'd400, 5, 0, 1);
        checks++; if (obs_q.size() != 3) begin failures++; $display("FAIL stale_edge_count got=%0d exp=3", obs_q.size()); end
        for (int i = 0; i < obs_q.size() && i < 3; i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL stale_edge%0d got=%h exp=%h", i, obs_q[i], exp_q[i]); end
        end
        checks++; if (done_c != 1 + 3 * (SC + 5 + 2)) begin failures++; $display("FAIL stale_done_cycle got=%0d exp=%0d", done_c, 1 + 3 * (SC + 7)); end
        stale_hold = 0;
    endtask

    task automatic test_timeout();
        do_reset();
        build_exp(10'd10, 9'd20, 10'd20, 9'd20, 10'd10, 9'd30);
        run_tri(10'd10, 9'd20, 10'd20, 9'd20, 10'd10, 9'd30, 0, 1, 0);
        checks++; if (first_wait != 2 + SC) begin failures++; $display("FAIL to_first_wait got=%0d exp=%0d", first_wait, 2 + SC); end
        checks++; if (err_c != first_wait + TO) begin failures++; $display("FAIL to_err_cycle got=%0d exp=%0d", err_c, first_wait + TO); end
        checks++; if (err_edge != 0) begin failures++; $display("FAIL to_edge_idx got=%0d exp=0", err_edge); end
        checks++; if (obs_q.size() != 1) begin failures++; $display("FAIL to_edges_issued got=%0d exp=1", obs_q.size()); end
        checks++; if (ready_after !== 1'b1) begin failures++; $display("FAIL to_ready_after got=%b exp=1", ready_after); end
        checks++; if (done_cnt != 0 || err_cnt != 1) begin failures++; $display("FAIL to_pulses got=done%0d/err%0d exp=done0/err1", done_cnt, err_cnt); end
        never_fin = 0;
    endtask

    task automatic test_back_to_back();
        logic [9:0] x2a, x2b, x2c;
        logic [8:0] y2a, y2b, y2c;
        bit seen, prev_start;
        int c, early;
        do_reset();
        fin_delay = 2; never_fin = 0; stale_hold = 0;
        x2a = 10'($urandom_range(0, 639)); y2a = 9'($urandom_range(0, 479));
        x2b = 10'($urandom_range(0, 639)); y2b = 9'($urandom_range(0, 479));
        x2c = 10'($urandom_range(0, 639)); y2c = 9'($urandom_range(0, 479));
        build_exp(10'd100, 9'd50, 10'd300, 9'd60, 10'd200, 9'd400);
        ax = 10'd100; ay = 9'd50; bx = 10'd300; by = 9'd60; cx = 10'd200; cy = 9'd400;
        tri_valid = 1'b1;
        tick();
        ax = x2a; ay = y2a; bx = x2b; by = y2b; cx = x2c; cy = y2c;
        obs_q.delete();
        seen = 0; c = 1; early = 0; prev_start = 1'b1;
        while (!seen && c < 400) begin
            if (prev_start && !line_start) obs_q.push_back({line_x1, line_y1, line_x2, line_y2});
            if (done) seen = 1;
            else if (tri_ready) early++;
            prev_start = line_start;
            tick(); c++;
        end
        checks++; if (!seen) begin failures++; $display("FAIL b2b_first_done got=none exp=pulse"); end
        checks++; if (early != 0) begin failures++; $display("FAIL b2b_ready_while_busy got=%0d exp=0", early); end
        checks++; if (obs_q.size() != 3) begin failures++; $display("FAIL b2b_t1_edge_count got=%0d exp=3", obs_q.size()); end
        for (int i = 0; i < obs_q.size() && i < 3; i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL b2b_t1_edge%0d got=%h exp=%h", i, obs_q[i], exp_q[i]); end
        end
        checks++; if (tri_ready !== 1'b1) begin failures++; $display("FAIL b2b_idle_after_done got=%b exp=1", tri_ready); end
        tick();
        tri_valid = 1'b0;
        build_exp(x2a, y2a, x2b, y2b, x2c, y2c);
        checks++; if (busy !== 1'b1 || tri_ready !== 1'b0) begin failures++; $display("FAIL b2b_t2_accept got=busy%b/ready%b exp=busy1/ready0", busy, tri_ready); end
        checks++; if (edge_idx !== 2'd0) begin failures++; $display("FAIL b2b_t2_edge_idx got=%0d exp=0", edge_idx); end
        checks++;
        if ({line_x1, line_y1, line_x2, line_y2} !== exp_q[0]) begin
            failures++; $display("FAIL b2b_t2_ab got=%h exp=%h", {line_x1, line_y1, line_x2, line_y2}, exp_q[0]);
        end
        c = 0;
        while (!tri_ready && c < 400) begin tick(); c++; end
        checks++; if (!tri_ready) begin failures++; $display("FAIL b2b_t2_drain got=busy exp=idle"); end
    endtask

    task automatic test_reset_mid_wait();
        int c, dcount;
        do_reset();
        fin_delay = 10; never_fin = 0; stale_hold = 0;
        ax = 10'd1; ay = 9'd2; bx = 10'd600; by = 9'd300; cx = 10'd40; cy = 9'd470;
        tri_valid = 1'b1;
        tick();
        tri_valid = 1'b0;
        c = 0; dcount = 0;
        while (!(edge_idx == 2'd1 && !line_start) && c < 400) begin tick(); c++; end
        checks++; if (c >= 400) begin failures++; $display("FAIL rst_mid_reach_wait1 got=timeout exp=wait_edge1"); end
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        checks++;
        if (line_start !== 1'b1 || busy !== 1'b0 || edge_idx !== 2'd0 || tri_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_state got=start%b busy%b edge%0d ready%b exp=start1 busy0 edge0 ready1",
                     line_start, busy, edge_idx, tri_ready);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 80; k++) begin
            tick();
            if (done) dcount++;
        end
        checks++; if (dcount != 0) begin failures++; $display("FAIL rst_mid_no_done got=%0d exp=0", dcount); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_mid_stays_idle got=%b exp=0", busy); end
    endtask

    initial begin
        test_reset();
        test_edge_order();
        test_random();
        test_stale_finish();
        test_timeout();
        test_back_to_back();
        test_reset_mid_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tri_edge_sequencer.md
# tri_edge_sequencer

Front-end stage of the line/triangle path. Accepts one triangle (three vertices) per handshake and drives the Bresenham line engine directly downstream three times, once per edge (AB, BC, CA). For each edge it presents endpoints, holds the engine's `start` input, waits for its `finish`, and moves to the next edge. It reports completion, or a timeout if the engine stalls.

## Interface
- `COORD_W`, default 32: width of the coordinate outputs to the line engine; vertices are zero-extended into it.
- `START_CYCLES`, default 2: number of cycles `line_start` is held high per edge (minimum 1).
- `TIMEOUT`, default 2048: maximum number of WAIT cycles per edge before the sequencer aborts (minimum 2).

Ports:
- `clk`, in, 1: single clock; all logic is on the rising edge.
- `rst_n`, in, 1: synchronous, active-low reset.
- `tri_valid`, in, 1: a triangle is offered on `ax..cy`.
- `tri_ready`, out, 1: the sequencer can accept a triangle.
- `ax`, `bx`, `cx`, in, 10 each: vertex X coordinates (0..639).
- `ay`, `by`, `cy`, in, 9 each: vertex Y coordinates (0..479).
- `line_start`, out, 1: to the engine's `start` input; high parks or resets the engine.
- `line_x1`, `line_y1`, `line_x2`, `line_y2`, out, COORD_W each: edge endpoints to the engine.
- `line_finish`, in, 1: from the engine's `finish` output.
- `busy`, out, 1: a triangle is in progress.
- `edge_idx`, out, 2: current edge, 0=AB, 1=BC, 2=CA.
- `done`, out, 1: one-cycle pulse when all three edges have completed.
- `timeout_err`, out, 1: one-cycle pulse when an edge is aborted on timeout.

## Operation
- States:
  - IDLE: `tri_ready`=1, `line_start`=1. `tri_valid&tri_ready` captures all six coordinates, sets `edge_idx`=0 and moves to LOAD.
  - LOAD: registers the endpoints for `edge_idx` onto the `line_*` outputs, clears the cycle counter, and moves to START.
  - START: `line_start`=1 for exactly START_CYCLES cycles, counted from entry, then moves to WAIT.
  - WAIT: `line_start`=0.
    - `line_finish`=1: if `edge_idx`=2, go to DONE; otherwise increment `edge_idx` and go to LOAD.
    - Counter reaches TIMEOUT−1 with `line_finish`=0: go to ERR.
  - DONE: `done`=1 for one cycle, then IDLE.
  - ERR: `timeout_err`=1 for one cycle, remaining edges are abandoned, then IDLE.
- `line_start` is high in IDLE, LOAD, START, DONE and ERR. This keeps the engine parked and clears its `finish` between edges.
- `line_finish` is sampled only in WAIT. A stale `finish` that is still high from the previous edge during LOAD or START is ignored.
- Edge endpoints: AB=(A,B), BC=(B,C), CA=(C,A). Coordinates are zero-extended to COORD_W. The `line_*` outputs stay stable from LOAD through the end of WAIT.
- Degenerate triangles (coincident vertices) are not special-cased; all three edges are still issued.
- `tri_valid` is ignored whenever `tri_ready`=0.
- `busy`=1 in every state except IDLE.
- Reset values:
  - state=IDLE, `tri_ready`=1, `line_start`=1, `line_*`=0.
  - `busy`=0, `edge_idx`=0, `done`=0, `timeout_err`=0, cycle counter=0.
- Reset asserted mid-operation: all of the above take effect on that clock edge, and the in-flight triangle is dropped.

## Timing
- Acceptance edge n puts the sequencer in LOAD at cycle n+1, START at n+2, and WAIT at n+2+START_CYCLES.
- Per-edge overhead is 1 (LOAD) + START_CYCLES + 1 (finish sample) cycles, plus the engine's run time.
- `done` is asserted in the cycle after the WAIT cycle that sampled `finish` for edge 2. `tri_ready` returns high one cycle later.
- `timeout_err` is asserted after exactly TIMEOUT WAIT cycles without `finish`. `tri_ready` returns high one cycle later.
- There is no combinational path from any input to any output; all outputs are registered or decoded from state.

## Configuration
- `TRI_EDGE_SORT_EN` defined: each edge is normalised before issue.
  - Endpoints are swapped so that x1<x2.
  - If x1==x2, they are swapped so that y1≤y2.
  - `edge_idx` still reflects the AB/BC/CA order.
- `TRI_EDGE_SORT_EN` undefined: endpoints are issued exactly in vertex order.

## Test plan
- Edge order: A(10,20), B(20,20), C(10,30); engine stub asserts `finish` 12 cycles after `start` falls.
  - Required endpoints: (10,20)->(20,20), then (20,20)->(10,30), then (10,30)->(10,20).
  - `done` pulses once and `busy` falls with it.
- `TRI_EDGE_SORT_EN` defined, same triangle: BC is issued as (10,30)->(20,20) and CA as (10,20)->(10,30).
- TIMEOUT=16, stub never asserts `finish`:
  - `timeout_err` is high exactly 16 cycles after WAIT is entered for edge 0.
  - `edge_idx` stays 0; `tri_ready`=1 on the next cycle.
- Stale finish: stub holds `finish`=1 through LOAD and START, then drops it for 5 cycles after `start` falls before reasserting. The sequencer must not advance before that reassertion.
- Backpressure: `tri_valid` held high for the whole run with a second triangle applied. The second triangle is accepted only in the first IDLE cycle after `done`, and its AB endpoints then appear.
- Reset mid-WAIT on edge 1: on the next cycle `line_start`=1, `busy`=0, `edge_idx`=0, `tri_ready`=1, and no `done` is ever pulsed for the dropped triangle.
